mna_flit_builder: RTL and testbench

//  Master-side NoC adapter stage: packs one AXI4-Lite request (address, write flag, write data) into a 3-flit packet.

---
 rtl/mna_flit_builder.sv | 74 +++++++
 tb/tb_mna_flit_builder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mna_flit_builder.sv
// Packs one AXI4-Lite request into a header/body/tail flit triple on the lowest free VC.
// CHECKSUM_EN: when defined, the tail carries an XOR of the address and body payload bytes.
module mna_flit_builder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_VC = 8,
  parameter int VC_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     awrite,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_VC-1:0]        is_allocatable,
  output logic                     flits_valid,
  input  logic                     flits_ack,
  output logic [2+VC_W+DATA_W-1:0] header,
  output logic [2+VC_W+DATA_W-1:0] body,
  output logic [2+VC_W+DATA_W-1:0] tail
);

  localparam logic [1:0] TYPE_HEADER = 2'b00;
  localparam logic [1:0] TYPE_BODY   = 2'b01;
  localparam logic [1:0] TYPE_TAIL   = 2'b10;

  logic [VC_W-1:0]   vc_sel;
  logic              vc_any;
  logic              accept;
  logic [DATA_W-1:0] payload;
  logic [7:0]        chk;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    vc_sel = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (is_allocatable[i]) vc_sel = VC_W'(i);
    end
  end

  assign vc_any    = |is_allocatable;
  assign req_ready = (!flits_valid || flits_ack) && vc_any;
  assign accept    = req_valid && req_ready;
  assign payload   = awrite ? wdata : '0;

`ifdef CHECKSUM_EN
  always_comb begin
    chk = 8'h00;
    for (int k = 0; k < ADDR_W / 8; k++) chk = chk ^ addr[8*k +: 8];
    for (int k = 0; k < DATA_W / 8; k++) chk = chk ^ payload[8*k +: 8];
  end
`else
  assign chk = 8'h00;
`endif

  // Flit registers are only written on accept, so an ack alone leaves the last packet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flits_valid <= 1'b0;
      header      <= '0;
      body        <= '0;
      tail        <= '0;
    end else if (accept) begin
      flits_valid <= 1'b1;
      header      <= {TYPE_HEADER, vc_sel, addr[DATA_W-1:0]};
      body        <= {TYPE_BODY, vc_sel, payload};
      tail        <= {TYPE_TAIL, vc_sel, awrite, {(DATA_W-9){1'b0}}, chk};
    end else if (flits_ack) begin
      flits_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mna_flit_builder.sv
// Directed checks of the documented vectors, then random traffic against a packet-level scoreboard.
module tb_mna_flit_builder;

  logic        clk, rst_n;
  logic        req_valid, req_ready, awrite, flits_valid, flits_ack;
  logic [31:0] addr, wdata;
  logic [7:0]  is_allocatable;
  logic [36:0] header, body, tail;

  int errors = 0;
  int checks = 0;
  bit rand_on = 0;

  typedef struct {
    logic [36:0] h, b, t;
  } pkt_t;
  pkt_t exp_q[$];

`ifdef CHECKSUM_EN
  localparam logic [36:0] T3_TAIL = 37'h11_8000_0015;
`else
  localparam logic [36:0] T3_TAIL = 37'h11_8000_0000;
`endif

  mna_flit_builder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .awrite(awrite), .wdata(wdata), .is_allocatable(is_allocatable),
    .flits_valid(flits_valid), .flits_ack(flits_ack),
    .header(header), .body(body), .tail(tail)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: packet contents straight from the field definitions.
  function automatic pkt_t model(input logic [31:0] a, input logic w,
                                 input logic [31:0] d, input logic [7:0] alloc);
    pkt_t        p;
    logic [2:0]  vc = 3'd0;
    bit          found = 0;
    logic [31:0] pl = w ? d : 32'h0;
    logic [7:0]  c = 8'h00;
    for (int i = 0; i < 8; i++)
      if (alloc[i] && !found) begin
        vc = 3'(i);
        found = 1;
      end
`ifdef CHECKSUM_EN
    for (int k = 0; k < 4; k++) c = c ^ a[8*k +: 8] ^ pl[8*k +: 8];
`endif
    p.h = {2'b00, vc, a};
    p.b = {2'b01, vc, pl};
    p.t = {2'b10, vc, w, 23'h0, c};
    return p;
  endfunction

  // Monitor: whenever a packet is presented it must match the oldest outstanding one.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rand_on && flits_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_packet", {36'h0, flits_valid}, 37'h0);
        end else begin
          check("rand_header", header, exp_q[0].h);
          check("rand_body", body, exp_q[0].b);
          check("rand_tail", tail, exp_q[0].t);
          if (flits_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit         mv;
    bit         took;
    logic       exp_rdy;
    rst_n = 0; req_valid = 0; addr = 0; awrite = 0; wdata = 0;
    is_allocatable = 8'h00; flits_ack = 0;

    // Reset state
    #3;
    check("rst_ready_none", {36'h0, req_ready}, 37'h0);
    check("rst_valid", {36'h0, flits_valid}, 37'h0);
    check("rst_header", header, 37'h0);
    check("rst_body", body, 37'h0);
    check("rst_tail", tail, 37'h0);
    is_allocatable = 8'h01;
    #1 check("rst_ready_some", {36'h0, req_ready}, 37'h1);

    // Read on VC7
    @(negedge clk);
    rst_n = 1; req_valid = 1; is_allocatable = 8'h80; addr = 0; awrite = 0; wdata = 32'h1;
    @(posedge clk); #1;
    check("rd_header", header, 37'h07_0000_0000);
    check("rd_body", body, 37'h0F_0000_0000);
    check("rd_tail", tail, 37'h17_0000_0000);
    check("rd_valid", {36'h0, flits_valid}, 37'h1);

    // Write pending behind 3 cycles of backpressure, then ack+accept together
    @(negedge clk);
    is_allocatable = 8'h06; addr = 32'h1000_0004; awrite = 1; wdata = 32'hA5A5_0001;
    repeat (3) begin
      #1 check("bp_ready", {36'h0, req_ready}, 37'h0);
      @(posedge clk); #1;
      check("bp_header_frozen", header, 37'h07_0000_0000);
      check("bp_valid", {36'h0, flits_valid}, 37'h1);
      @(negedge clk);
    end
    flits_ack = 1;
    #1 check("ack_ready", {36'h0, req_ready}, 37'h1);
    @(posedge clk); #1;
    check("wr_header", header, 37'h01_1000_0004);
    check("wr_body", body, 37'h09_A5A5_0001);
    check("wr_tail", tail, T3_TAIL);
    check("wr_valid", {36'h0, flits_valid}, 37'h1);

    // No VC free: ack drains, request stalls, flits keep last values
    @(negedge clk);
    is_allocatable = 8'h00; addr = 32'h20; wdata = 32'h1234_5678; flits_ack = 1;
    #1 check("stall_ready", {36'h0, req_ready}, 37'h0);
    @(posedge clk); #1;
    check("stall_valid", {36'h0, flits_valid}, 37'h0);
    check("stall_header_kept", header, 37'h01_1000_0004);
    @(negedge clk);
    flits_ack = 0; is_allocatable = 8'h01;
    #1 check("unstall_ready", {36'h0, req_ready}, 37'h1);
    @(posedge clk); #1;
    check("unstall_header", header, 37'h00_0000_0020);
    check("unstall_valid", {36'h0, flits_valid}, 37'h1);

    // Asynchronous reset while a packet is held
    @(negedge clk);
    req_valid = 0;
    #2 rst_n = 0;
    #1;
    check("arst_valid", {36'h0, flits_valid}, 37'h0);
    check("arst_header", header, 37'h0);
    @(negedge clk);
    rst_n = 1;

    // Random traffic
    mv = 0;
    took = 0;
    rand_on = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!req_valid || took) begin
        req_valid = ($urandom_range(0, 2) != 0);
        addr      = $urandom;
        awrite    = $urandom_range(0, 1);
        wdata     = $urandom;
      end
      is_allocatable = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      flits_ack      = $urandom_range(0, 1);
      #1;
      exp_rdy = (!mv || flits_ack) && (is_allocatable != 8'h00);
      check("rand_ready", {36'h0, req_ready}, {36'h0, exp_rdy});
      check("rand_valid", {36'h0, flits_valid}, {36'h0, mv});
      took = req_valid && exp_rdy;
      if (took) begin
        exp_q.push_back(model(addr, awrite, wdata, is_allocatable));
        mv = 1;
      end else if (flits_ack) begin
        mv = 0;
      end
    end

    // Drain whatever is outstanding
    @(negedge clk);
    req_valid = 0;
    flits_ack = 1;
    repeat (4) @(negedge clk);
    #3;
    check("drain_queue_empty", 37'(exp_q.size()), 37'h0);
    check("drain_valid", {36'h0, flits_valid}, 37'h0);
    rand_on = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
